// File: rtl/toggle_seq_ctrl_if.sv
// Requester-side bundle of the toggle sequencer.
// master = requesters, slave = controller.
interface toggle_seq_ctrl_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_level;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             err;
  logic             busy;

  modport master (
    output req, req_level,
    input  gnt, done, err, busy
  );

  modport slave (
    input  req, req_level,
    output gnt, done, err, busy
  );
endinterface

// File: rtl/toggle_seq_ctrl.sv
// Round-robin sequencer owning din of a toggle FSM;
// pulses din only on level mismatch, confirms via dout_fb.
module toggle_seq_ctrl #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  toggle_seq_ctrl_if.slave   bus,
  output logic               din,
  input  logic               dout_fb
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] TMAX =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] gnt_q;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] timer;
  logic             level;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [N_REQ-1:0] win_oh;

  // first set req strictly after rr_ptr, wrapping
  always_comb begin
    int j;
    j      = 0;
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(rr_ptr) + i) % N_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      gnt_q  <= '0;
      gidx   <= '0;
      rr_ptr <= IDX_W'(N_REQ - 1);
      timer  <= '0;
      level  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            gnt_q <= win_oh;
            gidx  <= win;
            level <= bus.req_level[win];
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= (dout_fb == level) ?
                   S_DONE : S_PULSE;
        end
        S_PULSE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (dout_fb == level)
            state <= S_DONE;
          else if (timer == TMAX)
            state <= S_ERR;
          else
            timer <= timer + 1'b1;
        end
        S_DONE, S_ERR: begin
          rr_ptr <= gidx;
          gnt_q  <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic fin;
  assign fin      = (state == S_DONE) ||
                    (state == S_ERR);
  assign bus.gnt  = gnt_q;
  assign bus.done = fin ? gnt_q : '0;
  assign bus.err  = (state == S_ERR);
  assign bus.busy = (state != S_IDLE);
  assign din      = (state == S_PULSE);

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Directed bench for toggle_seq_ctrl with a
// behavioural toggle FSM on din/dout_fb.
module tb_toggle_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic fsm_rst_n;
  logic din;
  logic dout_fb;
  int   tests = 0;
  int   fails = 0;
  int   pcnt  = 0;
  int   dbl   = 0;
  logic prev_din = 1'b0;
  logic seen;

  toggle_seq_ctrl_if #(.N_REQ(2)) bus();

  toggle_seq_ctrl #(
    .N_REQ(2),
    .TIMEOUT(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .din(din),
    .dout_fb(dout_fb)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) dout_fb <= 1'b0;
    else if (din)   dout_fb <= ~dout_fb;
  end

  always @(posedge clk) begin
    pcnt     <= pcnt + int'(din);
    dbl      <= dbl + int'(din & prev_din);
    prev_din <= din;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  logic [1:0] exp_g [4];
  logic       exp_d [4];

  initial begin
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    fsm_rst_n = 1'b1;
    bus.req = '0;
    bus.req_level = '0;
    #1;
    rst = 1'b0;
    fsm_rst_n = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_din", din, 0);
    tick();
    rst = 1'b1;
    fsm_rst_n = 1'b1;
    tick();

    // T1: toggle 0 -> 1 for requester 0
    bus.req = 2'b01;
    bus.req_level = 2'b01;
    tick();
    chk("t1_gnt", bus.gnt, 2'b01);
    chk("t1_busy", bus.busy, 1);
    chk("t1_din_chk", din, 0);
    tick();
    chk("t1_din", din, 1);
    tick();
    chk("t1_din_off", din, 0);
    chk("t1_dout", dout_fb, 1);
    chk("t1_early", bus.done, 0);
    tick();
    chk("t1_done", bus.done, 2'b01);
    chk("t1_err", bus.err, 0);
    bus.req = '0;
    tick();
    chk("t1_idle", bus.busy, 0);
    chk("t1_gnt0", bus.gnt, 0);
    chk("t1_pcnt", pcnt, 1);

    // T2: already at target level
    bus.req = 2'b01;
    bus.req_level = 2'b01;
    tick();
    chk("t2_gnt", bus.gnt, 2'b01);
    tick();
    chk("t2_done", bus.done, 2'b01);
    chk("t2_din", din, 0);
    chk("t2_dout", dout_fb, 1);
    bus.req = '0;
    tick();
    chk("t2_idle", bus.busy, 0);
    chk("t2_pcnt", pcnt, 1);

    // T3: both requesting, rr_ptr=0 so req1 first
    bus.req = 2'b11;
    bus.req_level = 2'b10;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (bus.done != 0) seen = 1'b1;
      end
      chk("t3_seen", seen, 1);
      chk("t3_done", bus.done, exp_g[k]);
      chk("t3_gnt", bus.gnt, exp_g[k]);
      chk("t3_err", bus.err, 0);
      chk("t3_dout", dout_fb, exp_d[k]);
      if (k == 3) bus.req = '0;
      tick();
      chk("t3_gap", bus.busy, 0);
    end
    chk("t3_pcnt", pcnt, 4);

    // T4: FSM held in reset -> timeout
    fsm_rst_n = 1'b0;
    bus.req = 2'b10;
    bus.req_level = 2'b10;
    tick();
    chk("t4_gnt", bus.gnt, 2'b10);
    tick();
    chk("t4_din", din, 1);
    for (int c = 0; c < 8; c++) tick();
    chk("t4_wait_err", bus.err, 0);
    chk("t4_wait_busy", bus.busy, 1);
    chk("t4_wait_din", din, 0);
    tick();
    chk("t4_err", bus.err, 1);
    chk("t4_done", bus.done, 2'b10);
    bus.req = '0;
    tick();
    chk("t4_idle", bus.busy, 0);
    chk("t4_err0", bus.err, 0);
    chk("t4_pcnt", pcnt, 5);

    // T5: async reset in WAIT
    bus.req = 2'b01;
    bus.req_level = 2'b01;
    tick();
    chk("t5_gnt", bus.gnt, 2'b01);
    tick();
    tick();
    tick();
    chk("t5_wait", bus.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_gnt0", bus.gnt, 0);
    chk("t5_busy0", bus.busy, 0);
    chk("t5_din0", din, 0);
    chk("t5_done0", bus.done, 0);
    tick();
    chk("t5_nodone", bus.done, 0);
    rst = 1'b1;
    fsm_rst_n = 1'b1;
    bus.req = 2'b11;
    bus.req_level = 2'b00;
    tick();
    chk("t5_rr", bus.gnt, 2'b01);
    tick();
    chk("t5_done", bus.done, 2'b01);
    bus.req = '0;
    tick();
    chk("t5_idle", bus.busy, 0);
    chk("t5_pcnt", pcnt, 6);

    // T6: req/level change after grant ignored
    bus.req = 2'b01;
    bus.req_level = 2'b01;
    tick();
    chk("t6_gnt", bus.gnt, 2'b01);
    bus.req = '0;
    bus.req_level = '0;
    tick();
    chk("t6_din", din, 1);
    tick();
    chk("t6_dout", dout_fb, 1);
    tick();
    chk("t6_done", bus.done, 2'b01);
    chk("t6_err", bus.err, 0);
    tick();
    chk("t6_idle", bus.busy, 0);
    tick();
    chk("t6_stay", bus.busy, 0);
    chk("t6_pcnt", pcnt, 7);
    chk("din_dbl", dbl, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
